sprite_scheduler: RTL and testbench
===================================

// Module: sprite_scheduler
// PURPOSE
//  Shares one glyph ROM (3-bit colour-index output) between N_SPRITES on-screen letter sprites.
//  Each pixel: picks the highest-priority enabled sprite covering (counterX,counterY) and issues its ROM address.
//  Outputs the colour index, pipeline-aligned with the ROM, to the rgbDecoder ahead of VGA out.
//  CPU writes a shadow table through MMIO; shadow is copied to the active table during vertical blank.
// PARAMETERS
//  N_SPRITES   8   sprite slots; index 0 = highest priority
//  SPR_SIZE    32  sprite edge in pixels (power of 2); one glyph = SPR_SIZE*SPR_SIZE ROM words
//  GLYPH_W     3   glyph-code width -> ROM holds 2**GLYPH_W glyphs
//  ROM_LAT     1   ROM read latency in clocks (0 = combinational ROM)
// PORTS
//  clk         in   1    pixel clock
//  rst_n       in   1    asynchronous reset, active-low
//  counterX    in   13   current pixel column
//  counterY    in   13   current pixel row
//  video_on    in   1    high inside visible area
//  frame_start in   1    1-cycle pulse at start of vertical blank
//  wr_en       in   1    shadow-table write strobe
//  wr_idx      in   $clog2(N_SPRITES)  slot written
//  wr_x,wr_y   in   10   sprite top-left corner
//  wr_glyph    in   GLYPH_W  glyph code
//  wr_vis      in   1    slot enable
//  commit_req  in   1    pulse: request shadow->active copy at next frame_start
//  wr_ready    out  1    low while COPY; wr_en ignored when low
//  commit_pend out  1    commit requested, not yet done
//  rom_addr    out  GLYPH_W+2*$clog2(SPR_SIZE)  shared ROM address
//  rom_color   in   3    ROM data
//  pix_color   out  3    colour index, valid with pix_hit
//  pix_hit     out  1    a sprite covers the pixel
//  pix_idx     out  $clog2(N_SPRITES)  winning slot
// BEHAVIOUR
//  Reset: both tables cleared (vis=0, x=y=glyph=0), FSM=IDLE, all outputs 0, wr_ready=1.
//  Hit test (stage 0, combinational): slot i hits iff vis && x<=cX<x+SIZE && y<=cY<y+SIZE && video_on.
//    Compare at 13+1 bits; x+SIZE never wraps, so a sprite past the right/bottom edge is clipped, never wrapped.
//  Priority: lowest hitting index wins; no hit -> rom_addr=0, hit flag 0.
//  Stage 1 (registered): rom_addr = {glyph, row, col}, row=cY-y, col=cX-x (log2 SIZE bits each).
//    Registered alongside: hit and idx.
//  hit/idx delayed ROM_LAT more cycles. pix_color = hit ? rom_color : 0. Pixel->output latency = 1+ROM_LAT clocks.
//  Shadow write: on wr_en && wr_ready, slot wr_idx <= {wr_x,wr_y,wr_glyph,wr_vis} at the next edge.
//  FSM:
//    IDLE -> PEND on commit_req.
//    PEND -> COPY on frame_start.
//    COPY copies one slot per clock, index 0..N-1, then returns to IDLE. wr_ready=0 only in COPY.
//  commit_pend=1 in PEND and COPY.
//  commit_req and wr_en in the same cycle: the write lands in shadow first and is included in the commit.
//  commit_req in PEND or COPY: ignored (single pending commit).
//  frame_start in IDLE or COPY: ignored.
//  Active table changes only in COPY. Hit logic keeps reading the active table during the copy.
//  COPY finishes in N_SPRITES clocks, well inside vblank.
//  Async reset mid-COPY: FSM to IDLE, both tables cleared, partial copy discarded.
// STRUCTURE
//  sprite_pkg:
//    typedef sprite_t {x[9:0], y[9:0], glyph[GLYPH_W-1:0], vis}
//    enum sched_state_t {IDLE, PEND, COPY}
//    constant localparam for the address-width formula
//  One sub-module, sprite_hit_unit: per-slot bounding-box compare.
//    Instantiated N_SPRITES times.
//    The parent does the priority encode, address pipeline and FSM.
// TESTING (bench: 8 slots, SIZE=32, ROM_LAT=1, behavioural ROM data = addr[2:0])
//  1. Reset, no writes, sweep a line -> pix_hit=0, pix_color=0, rom_addr=0 throughout.
//  2. Write slot 2 {x=100,y=50,glyph=3,vis=1} + commit_req, pulse frame_start.
//     -> commit_pend falls after 8 clocks.
//     -> pixel (105,60): rom_addr={3,10,5}, pix_hit=1, pix_idx=2, 2 clocks later.
//  3. Slots 1 and 4 overlap at (200,200) -> pix_idx=1.
//     Disable slot 1 + commit -> next frame pix_idx=4.
//  4. Slot at x=1000 -> hits at cX=1000..1031 only, no hit at cX=0..7 (no wrap).
//     Pixel (1031,y) hit, (1032,y) none.
//  5. Write slot 0 without commit_req -> active output unchanged for 3 frames.
//     wr_en during COPY -> dropped, shadow unchanged.
//  6. Assert rst_n low mid-COPY (after 3 slots) -> FSM=IDLE, commit_pend=0, all outputs 0 immediately.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite-table types, scheduler states and ROM address-width helper
package sprite_pkg;
   localparam int SPR_GLYPH_W = 3;
   localparam int SPR_SIZE_D  = 32;
   typedef struct packed {
      logic [9:0]             x;
      logic [9:0]             y;
      logic [SPR_GLYPH_W-1:0] glyph;
      logic                   vis;
   } sprite_t;
   typedef enum logic [1:0] {IDLE, PEND, COPY} sched_state_t;
   function automatic int addr_w(input int glyph_w, input int size);
      return glyph_w + 2 * $clog2(size);
   endfunction
   localparam int ROM_ADDR_W = addr_w(SPR_GLYPH_W, SPR_SIZE_D);
endpackage

// File: rtl/sprite_hit_unit.sv
// sprite_hit_unit: bounding-box test of one sprite slot against the current pixel
module sprite_hit_unit
   import sprite_pkg::*;
#(
   parameter int SPR_SIZE = 32,
   parameter int LW       = $clog2(SPR_SIZE)
)(
   input  sprite_t       spr,
   input  logic [12:0]   cx,
   input  logic [12:0]   cy,
   input  logic          video_on,
   output logic          hit,
   output logic [LW-1:0] row,
   output logic [LW-1:0] col
);
   logic [13:0] px, py, x0, y0;
   assign px = {1'b0, cx};
   assign py = {1'b0, cy};
   assign x0 = {4'b0, spr.x};
   assign y0 = {4'b0, spr.y};
   // 14-bit compare: x0+SIZE cannot wrap, so right/bottom overflow clips
   assign hit = spr.vis && video_on && px >= x0 && px < x0 + 14'(SPR_SIZE)
              && py >= y0 && py < y0 + 14'(SPR_SIZE);
   assign row = LW'(py - y0);
   assign col = LW'(px - x0);
endmodule

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: shares one glyph ROM between prioritised sprites, with vblank-committed sprite table
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int N_SPRITES = 8,
   parameter int SPR_SIZE  = 32,
   parameter int GLYPH_W   = SPR_GLYPH_W,
   parameter int ROM_LAT   = 1,
   parameter int IW        = $clog2(N_SPRITES),
   parameter int LW        = $clog2(SPR_SIZE),
   parameter int AW        = addr_w(GLYPH_W, SPR_SIZE)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [12:0]        counterX,
   input  logic [12:0]        counterY,
   input  logic               video_on,
   input  logic               frame_start,
   input  logic               wr_en,
   input  logic [IW-1:0]      wr_idx,
   input  logic [9:0]         wr_x,
   input  logic [9:0]         wr_y,
   input  logic [GLYPH_W-1:0] wr_glyph,
   input  logic               wr_vis,
   input  logic               commit_req,
   output logic               wr_ready,
   output logic               commit_pend,
   output logic [AW-1:0]      rom_addr,
   input  logic [2:0]         rom_color,
   output logic [2:0]         pix_color,
   output logic               pix_hit,
   output logic [IW-1:0]      pix_idx
);
   sched_state_t         state_q, state_d;
   logic [IW-1:0]        cnt_q, cnt_d;
   sprite_t              shadow_q [N_SPRITES];
   sprite_t              shadow_d [N_SPRITES];
   sprite_t              active_q [N_SPRITES];
   sprite_t              active_d [N_SPRITES];
   logic [N_SPRITES-1:0] hit;
   logic [LW-1:0]        row [N_SPRITES];
   logic [LW-1:0]        col [N_SPRITES];
   logic [IW-1:0]        sel;
   logic [AW-1:0]        addr_q, addr_d;
   logic                 hit1_q, hit_o;
   logic [IW-1:0]        idx1_q, idx_o;

   for (genvar i = 0; i < N_SPRITES; i++) begin : g_hit
      sprite_hit_unit #(.SPR_SIZE(SPR_SIZE), .LW(LW)) u_hit (
         .spr(active_q[i]), .cx(counterX), .cy(counterY), .video_on(video_on),
         .hit(hit[i]), .row(row[i]), .col(col[i])
      );
   end

   always_comb begin
      sel = '0;
      for (int k = N_SPRITES - 1; k >= 0; k--) sel = hit[k] ? IW'(k) : sel;
   end
   assign addr_d = |hit ? AW'({active_q[sel].glyph, row[sel], col[sel]}) : '0;

   // shadow write is applied before the copy reads it, so a same-cycle write joins the commit
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_en && wr_ready)
         shadow_d[wr_idx] = '{x: wr_x, y: wr_y, glyph: wr_glyph, vis: wr_vis};
      case (state_q)
         IDLE: state_d = commit_req ? PEND : IDLE;
         PEND: state_d = frame_start ? COPY : PEND;
         default: begin
            active_d[cnt_q] = shadow_q[cnt_q];
            cnt_d   = (cnt_q == IW'(N_SPRITES - 1)) ? '0 : cnt_q + 1'b1;
            state_d = (cnt_q == IW'(N_SPRITES - 1)) ? IDLE : COPY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int k = 0; k < N_SPRITES; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
         addr_q  <= '0;
         hit1_q  <= 1'b0;
         idx1_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         addr_q   <= addr_d;
         hit1_q   <= |hit;
         idx1_q   <= sel;
      end
   end

   if (ROM_LAT == 0) begin : g_comb_rom
      assign hit_o = hit1_q;
      assign idx_o = idx1_q;
   end else begin : g_lat
      logic [ROM_LAT-1:0] hp_q, hp_d;
      logic [IW-1:0]      ip_q [ROM_LAT];
      logic [IW-1:0]      ip_d [ROM_LAT];
      always_comb begin
         hp_d    = ROM_LAT'({hp_q, hit1_q});
         ip_d[0] = idx1_q;
         for (int k = 1; k < ROM_LAT; k++) ip_d[k] = ip_q[k-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            hp_q <= '0;
            for (int k = 0; k < ROM_LAT; k++) ip_q[k] <= '0;
         end else begin
            hp_q <= hp_d;
            ip_q <= ip_d;
         end
      end
      assign hit_o = hp_q[ROM_LAT-1];
      assign idx_o = ip_q[ROM_LAT-1];
   end

   assign rom_addr    = addr_q;
   assign pix_hit     = hit_o;
   assign pix_idx     = idx_o;
   assign pix_color   = hit_o ? rom_color : 3'd0;
   assign wr_ready    = state_q != COPY;
   assign commit_pend = state_q != IDLE;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: directed checks of hit test, priority, ROM pipeline and commit FSM
module tb_sprite_scheduler;
   logic        clk = 0, rst_n = 0;
   logic [12:0] counterX = 0, counterY = 0;
   logic        video_on = 0, frame_start = 0, wr_en = 0, wr_vis = 0, commit_req = 0;
   logic [2:0]  wr_idx = 0, wr_glyph = 0;
   logic [9:0]  wr_x = 0, wr_y = 0;
   logic        wr_ready, commit_pend, pix_hit;
   logic [12:0] rom_addr;
   logic [2:0]  rom_color, pix_color, pix_idx, rom_q = 0;
   int          vecs = 0, errs = 0;

   always #5 clk = ~clk;
   always @(posedge clk) rom_q <= rom_addr[2:0];
   assign rom_color = rom_q;

   sprite_scheduler dut (
      .clk(clk), .rst_n(rst_n), .counterX(counterX), .counterY(counterY),
      .video_on(video_on), .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_x(wr_x), .wr_y(wr_y), .wr_glyph(wr_glyph), .wr_vis(wr_vis),
      .commit_req(commit_req), .wr_ready(wr_ready), .commit_pend(commit_pend),
      .rom_addr(rom_addr), .rom_color(rom_color), .pix_color(pix_color),
      .pix_hit(pix_hit), .pix_idx(pix_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input int idx, input int x, input int y, input int g, input logic v);
      wr_idx = 3'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_glyph = 3'(g); wr_vis = v;
      wr_en = 1;
      tick();
      wr_en = 0;
   endtask

   task automatic commit();
      commit_req = 1;
      tick();
      commit_req = 0;
      frame_start = 1;
      tick();
      frame_start = 0;
      repeat (8) tick();
   endtask

   task automatic pixel(input string tag, input int x, input int y,
                        input logic h, input int idx, input int addr);
      counterX = 13'(x); counterY = 13'(y);
      tick();
      chk({tag, "_addr"}, 32'(rom_addr), 32'(addr));
      tick();
      chk({tag, "_hit"}, 32'(pix_hit), 32'(h));
      if (h) chk({tag, "_idx"}, 32'(pix_idx), 32'(idx));
      chk({tag, "_color"}, 32'(pix_color), h ? 32'(addr % 8) : 32'd0);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_ready", 32'(wr_ready), 1);
      chk("rst_pend", 32'(commit_pend), 0);
      chk("rst_hit", 32'(pix_hit), 0);
      chk("rst_addr", 32'(rom_addr), 0);
      rst_n = 1;
      video_on = 1;
      counterY = 60;
      for (int i = 0; i < 16; i++) begin
         counterX = 13'(i * 70);
         tick();
         chk("empty_addr", 32'(rom_addr), 0);
         chk("empty_hit", 32'(pix_hit), 0);
         chk("empty_color", 32'(pix_color), 0);
      end
      counterX = 0;
      // write and commit request in the same cycle
      commit_req = 1;
      wr(2, 100, 50, 3, 1);
      commit_req = 0;
      chk("pend_wait", 32'(commit_pend), 1);
      chk("ready_pend", 32'(wr_ready), 1);
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("ready_copy", 32'(wr_ready), 0);
      repeat (7) tick();
      chk("pend_7", 32'(commit_pend), 1);
      tick();
      chk("pend_8", 32'(commit_pend), 0);
      chk("ready_done", 32'(wr_ready), 1);
      counterX = 105; counterY = 60;
      tick();
      chk("lat_addr", 32'(rom_addr), 3397);
      chk("lat_hit_early", 32'(pix_hit), 0);
      tick();
      chk("lat_hit", 32'(pix_hit), 1);
      chk("lat_idx", 32'(pix_idx), 2);
      chk("lat_color", 32'(pix_color), 5);
      video_on = 0;
      pixel("video_off", 105, 60, 0, 0, 0);
      video_on = 1;
      wr(1, 190, 190, 1, 1);
      wr(4, 195, 195, 4, 1);
      commit();
      pixel("prio_1", 200, 200, 1, 1, 1354);
      wr(1, 190, 190, 1, 0);
      commit();
      pixel("prio_4", 200, 200, 1, 4, 4261);
      wr(5, 1000, 100, 6, 1);
      commit();
      pixel("edge_1000", 1000, 100, 1, 5, 6144);
      pixel("edge_1031", 1031, 100, 1, 5, 6175);
      pixel("edge_1032", 1032, 100, 0, 0, 0);
      pixel("nowrap_0", 0, 100, 0, 0, 0);
      pixel("nowrap_7", 7, 100, 0, 0, 0);
      wr(0, 100, 50, 7, 1);
      repeat (3) begin
         frame_start = 1;
         tick();
         frame_start = 0;
         repeat (10) tick();
      end
      chk("nocommit_pend", 32'(commit_pend), 0);
      pixel("nocommit", 105, 60, 1, 2, 3397);
      commit_req = 1;
      tick();
      commit_req = 0;
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("copy_ready", 32'(wr_ready), 0);
      wr(0, 200, 200, 2, 1);
      repeat (7) tick();
      chk("copy_done", 32'(commit_pend), 0);
      pixel("slot0", 105, 60, 1, 0, 7493);
      commit();
      pixel("dropped_wr", 200, 200, 1, 4, 4261);
      commit_req = 1;
      tick();
      commit_req = 0;
      frame_start = 1;
      tick();
      frame_start = 0;
      repeat (3) tick();
      rst_n = 0;
      #1;
      chk("arst_pend", 32'(commit_pend), 0);
      chk("arst_ready", 32'(wr_ready), 1);
      chk("arst_hit", 32'(pix_hit), 0);
      chk("arst_addr", 32'(rom_addr), 0);
      chk("arst_color", 32'(pix_color), 0);
      chk("arst_idx", 32'(pix_idx), 0);
      tick();
      rst_n = 1;
      pixel("arst_clear", 105, 60, 0, 0, 0);
      commit();
      pixel("arst_shadow", 200, 200, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
